// File: rtl/word_collector4_pkg.sv
// word_collector4_pkg
//   Shared constants and state encoding for the 4-word collector.
//   COLLECT=0 gathers words into the slots, HOLD=1 presents a full frame.
package word_collector4_pkg;

    localparam int WORDS = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // True when idx addresses the last slot of a frame.
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(WORDS - 1);
    endfunction

endpackage

// File: rtl/word_collector4_slot.sv
// slot_reg
//   One WIDTH-bit data slot with write enable.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset, clears the slot to 0
//     i_we  - write enable
//     i_d   - write data
//     o_q   - stored word
module slot_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_q <= '0;
        else if (i_we) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/word_collector4.sv
// word_collector4
//   Collects four consecutive accepted words into a frame, then holds the
//   frame until downstream takes it. Handshakes are decoded from registered
//   state only, so a frame costs at least 5 cycles (4 accepts + 1 handoff).
//   Ports:
//     clk, rst            - clock; asynchronous active-low reset
//     in_data/in_valid    - upstream word and its valid
//     in_ready            - high while collecting (and out of reset)
//     clear               - drops a partial frame (ignored while holding)
//     out0..out3          - slot contents in arrival order
//     out_valid/out_ready - frame handoff handshake
//     frame_cnt           - frames handed off, modulo 256
module word_collector4
    import word_collector4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       frame_cnt
);

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [IDX_W-1:0]              r_idx;
    logic [7:0]                    r_frame_cnt;
    logic [WORDS-1:0][WIDTH-1:0]   w_slot;
    logic [WORDS-1:0]              w_we;
    logic                          w_collect;
    logic                          w_accept;
    logic                          w_handoff;

    assign w_collect = (r_state == COLLECT);
    // clear wins over a simultaneous accept: the presented word is dropped.
    assign w_accept  = w_collect && in_valid && !clear;
    assign w_handoff = (r_state == HOLD) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_accept && is_last_idx(r_idx)) w_state_nxt = HOLD;
            HOLD:    if (out_ready)                     w_state_nxt = COLLECT;
            default:                                    w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_collect && clear) r_idx <= '0;
            else if (w_accept)      r_idx <= r_idx + 1'b1;  // wraps 3 -> 0
            if (w_handoff)          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_slot
        assign w_we[g] = w_accept && (r_idx == IDX_W'(g));
        slot_reg #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst),
            .i_we  (w_we[g]),
            .i_d   (in_data),
            .o_q   (w_slot[g])
        );
    end

    // rst gating keeps in_ready low during reset; otherwise state decode only.
    assign in_ready  = rst && w_collect;
    assign out_valid = (r_state == HOLD);
    assign out0      = w_slot[0];
    assign out1      = w_slot[1];
    assign out2      = w_slot[2];
    assign out3      = w_slot[3];
    assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/word_collector4.md
WORD_COLLECTOR4 -- requirements
Module: word_collector4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the width of each data word.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data  input  WIDTH  incoming word.
REQ-005 The block SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 The block SHALL have port clear  input  1  synchronous abort of a partially collected frame.
REQ-008 The block SHALL have ports out0, out1, out2, out3  output  WIDTH each  four collected words, in arrival order.
REQ-009 The block SHALL have port out_valid  output  1  a complete 4-word frame is presented; it drives the downstream 4x32 register bank enable together with out_ready.
REQ-010 The block SHALL have port out_ready  input  1  downstream takes the frame this cycle.
REQ-011 The block SHALL have port frame_cnt  output  8  count of frames handed off, modulo 256.

Function
REQ-012 The block SHALL implement two states, COLLECT and HOLD.
REQ-013 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data is then written to slot idx (a 2-bit index, 0..3), and idx increments by 1.
REQ-015 When idx=3 is accepted, idx SHALL wrap to 0 and the state SHALL become HOLD, so out_valid=1 in the cycle after the 4th accept (latency 1 cycle).
REQ-016 In HOLD, in_ready SHALL be 0, out_valid SHALL be 1, and out0..out3 SHALL stay stable regardless of in_valid or in_data.
REQ-017 A handoff SHALL occur on a rising edge with out_valid=1 and out_ready=1; the state then returns to COLLECT and frame_cnt increments, wrapping from 255 to 0.
REQ-018 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from out_ready or in_valid; the minimum frame period is therefore 5 cycles.
REQ-019 Cycles with in_valid=0 SHALL leave idx, the slots and the state unchanged.
REQ-020 clear=1 in COLLECT SHALL reset idx to 0 on that edge; slot contents are don't-care and frame_cnt is unchanged.
REQ-021 clear has priority over a simultaneous accept: the word presented on that edge is dropped.
REQ-022 clear=1 in HOLD SHALL be ignored; a complete frame is never discarded.
REQ-023 During COLLECT, out0..out3 SHALL expose the slot registers (partial data); consumers use them only while out_valid=1.

Reset
REQ-024 rst=0 SHALL immediately force state=COLLECT, idx=0, out0..out3=0, frame_cnt=0 and out_valid=0, independent of clk.
REQ-025 in_ready SHALL be forced to 0 while rst=0, and SHALL become 1 in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the frame without counting it.

Structure
REQ-027 A shared package or defines file SHALL hold the state encoding (COLLECT=0, HOLD=1), the WORDS=4 constant and the index width of 2.
REQ-028 The block SHALL use one sub-module, slot_reg: a WIDTH-bit register with asynchronous active-low reset and a write enable, instantiated four times.

Verification
REQ-029 The bench SHALL cover frame fill: after reset, send 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 -> out_valid=1 one cycle after 0x44; out0..3=0x11,0x22,0x33,0x44; in_ready=0.
REQ-030 The bench SHALL cover hold and handoff: continuing from REQ-029, hold for 3 cycles, then out_ready=1 for one cycle -> outputs stable throughout the hold; frame_cnt 0->1; in_ready=1 on the next cycle.
REQ-031 The bench SHALL cover gaps: send 0xA,(idle),0xB,(idle 2),0xC,0xD -> frame 0xA,0xB,0xC,0xD, with idx unaffected by the idle cycles.
REQ-032 The bench SHALL cover clear priority: send 0x1,0x2, then 0x3 with clear=1 on the same edge, then 0x5..0x8 -> frame 0x5,0x6,0x7,0x8; frame_cnt unchanged by the clear.
REQ-033 The bench SHALL cover reset mid-frame and in HOLD: pulse rst=0 after 2 accepts, and separately while in HOLD -> all outputs 0 asynchronously; frame_cnt=0; the next 4 words form a clean frame.
REQ-034 The bench SHALL cover counter wrap: complete 256 back-to-back frames with out_ready=1 held -> frame_cnt returns to 0 and each frame takes exactly 5 cycles.
